// File: rtl/dw_fifo_s1_df.sv
// Single-clock FIFO with combinational status flags and selectable error and reset modes.
// Define DW_FIFO_S1_DF_OUTREG_EN to register data_out instead of muxing it straight from RAM.
module dw_fifo_s1_df #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned ERR_MODE = 0,
  parameter int unsigned RST_MODE = 0,
  localparam int unsigned ADDR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_req_n,
  input  logic              pop_req_n,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [ADDR_W-1:0] ae_level,
  input  logic [ADDR_W-1:0] af_thresh,
  output logic              empty,
  output logic              almost_empty,
  output logic              half_full,
  output logic              almost_full,
  output logic              full,
  output logic              error,
  output logic [CNT_W-1:0]  word_count,
  output logic [WIDTH-1:0]  data_out
);

  localparam int unsigned HalfLvl = (DEPTH + 1) / 2;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              error_q, error_d;
  logic              push_ok, pop_ok;
  logic              overflow, underflow;

  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + ADDR_W'(1);
  endfunction

  // Flags depend only on the registered count and the live threshold inputs.
  always_comb begin
    empty        = (count_q == '0);
    full         = (count_q == CNT_W'(DEPTH));
    half_full    = (32'(count_q) >= HalfLvl);
    almost_empty = (32'(count_q) <= 32'(ae_level));
    // Summed form avoids the negative DEPTH-af_thresh case when af_thresh > DEPTH.
    almost_full  = ((32'(count_q) + 32'(af_thresh)) >= DEPTH);
  end

  always_comb begin
    pop_ok    = ~pop_req_n & ~empty;
    push_ok   = ~push_req_n & (~full | pop_ok);
    overflow  = ~push_req_n & full & pop_req_n;
    underflow = ~pop_req_n & empty;

    wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_W'(1);
    end

    if (ERR_MODE == 0) begin
      error_d = error_q | overflow | underflow;
    end else begin
      error_d = overflow | underflow;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      error_q  <= error_d;
    end
  end

  generate
    if (RST_MODE == 0) begin : g_mem_rst
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
          end
        end else if (push_ok) begin
          mem[wr_ptr_q] <= data_in;
        end
      end
    end else begin : g_mem_nrst
      always_ff @(posedge clk) begin
        if (push_ok) begin
          mem[wr_ptr_q] <= data_in;
        end
      end
    end
  endgenerate

`ifdef DW_FIFO_S1_DF_OUTREG_EN
  logic [WIDTH-1:0] data_out_q;

  // Preload the next head; bypass when this edge writes the slot that becomes the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q <= '0;
    end else if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
      data_out_q <= data_in;
    end else begin
      data_out_q <= mem[rd_ptr_d];
    end
  end

  assign data_out = data_out_q;
`else
  assign data_out = mem[rd_ptr_q];
`endif

  assign word_count = count_q;
  assign error      = error_q;

endmodule
